// File: rtl/rtc_trig.sv
// Time-triggered event generator: watches the RTC time bus and emits a
// programmable-width pulse when a one-shot or periodic target is reached.
module rtc_trig #(
  parameter int PW_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [37:0]      time_reg_ns,
  input  logic [47:0]      time_reg_sec,
  input  logic [37:0]      time_acc_modulo,
  input  logic             trig_ld,
  input  logic             trig_cancel,
  input  logic [37:0]      trig_ns_in,
  input  logic [47:0]      trig_sec_in,
  input  logic [37:0]      period_ns_in,
  input  logic [15:0]      period_sec_in,
  input  logic [PW_W-1:0]  pulse_width,
  output logic             trig_out,
  output logic             trig_armed,
  output logic             trig_late,
  output logic             trig_err,
  output logic [CNT_W-1:0] trig_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic [PW_W-1:0]  PW_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic [37:0]      tgt_ns;
  logic [47:0]      tgt_sec;
  logic [37:0]      per_ns;
  logic [15:0]      per_sec;
  logic [PW_W-1:0]  width;
  logic [PW_W-1:0]  wcnt;
  logic             first;

  logic             hit;
  logic             periodic;
  logic             bad_period;
  logic [38:0]      ns_sum;
  logic [38:0]      ns_red;
  logic             ns_wrap;
  logic [37:0]      nxt_ns;
  logic [47:0]      nxt_sec;
  logic [PW_W-1:0]  pw_eff;

  // Both time buses are compared as one 86-bit unsigned value, so an
  // out-of-range target ns is honoured exactly as programmed.
  assign hit        = {time_reg_sec, time_reg_ns} >= {tgt_sec, tgt_ns};
  assign periodic   = (per_ns != 38'd0) || (per_sec != 16'd0);
  assign bad_period = period_ns_in >= time_acc_modulo;
  assign pw_eff     = (pulse_width == {PW_W{1'b0}}) ? PW_ONE : pulse_width;

  assign ns_sum  = {1'b0, tgt_ns} + {1'b0, per_ns};
  assign ns_red  = ns_sum - {1'b0, time_acc_modulo};
  assign ns_wrap = ns_sum >= {1'b0, time_acc_modulo};
  assign nxt_ns  = ns_wrap ? ns_red[37:0] : ns_sum[37:0];
  assign nxt_sec = tgt_sec + {32'd0, per_sec} + {47'd0, ns_wrap};

  // Trigger FSM with command handling, pulse timing and target reload
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tgt_ns     <= 38'd0;
      tgt_sec    <= 48'd0;
      per_ns     <= 38'd0;
      per_sec    <= 16'd0;
      width      <= {PW_W{1'b0}};
      wcnt       <= {PW_W{1'b0}};
      first      <= 1'b0;
      trig_out   <= 1'b0;
      trig_armed <= 1'b0;
      trig_late  <= 1'b0;
      trig_err   <= 1'b0;
      trig_cnt   <= {CNT_W{1'b0}};
    end else begin
      trig_late <= 1'b0;
      trig_err  <= 1'b0;
      if (trig_cancel) begin
        state      <= IDLE;
        trig_out   <= 1'b0;
        trig_armed <= 1'b0;
      end else if (trig_ld) begin
        // A rejected load freezes everything for this cycle.
        if (bad_period) begin
          trig_err <= 1'b1;
        end else begin
          tgt_ns     <= trig_ns_in;
          tgt_sec    <= trig_sec_in;
          per_ns     <= period_ns_in;
          per_sec    <= period_sec_in;
          width      <= pw_eff;
          first      <= 1'b1;
          state      <= ARMED;
          trig_out   <= 1'b0;
          trig_armed <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            trig_out   <= 1'b0;
            trig_armed <= 1'b0;
          end
          ARMED: begin
            first <= 1'b0;
            if (hit) begin
              trig_out  <= 1'b1;
              trig_cnt  <= trig_cnt + CNT_ONE;
              trig_late <= first;
              wcnt      <= width - PW_ONE;
              state     <= PULSE;
              if (periodic) begin
                tgt_ns  <= nxt_ns;
                tgt_sec <= nxt_sec;
              end else begin
                tgt_ns  <= tgt_ns;
                tgt_sec <= tgt_sec;
              end
            end else begin
              trig_out <= 1'b0;
            end
          end
          PULSE: begin
            if (wcnt == {PW_W{1'b0}}) begin
              trig_out <= 1'b0;
              // Re-arming counts as a fresh arm, so an already-passed
              // next target fires immediately and is flagged late.
              if (periodic) begin
                state <= ARMED;
                first <= 1'b1;
              end else begin
                state      <= IDLE;
                trig_armed <= 1'b0;
              end
            end else begin
              wcnt <= wcnt - PW_ONE;
            end
          end
          default: begin
            state      <= IDLE;
            trig_out   <= 1'b0;
            trig_armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
